// File: rtl/frame_parity_collector.sv
// Serial-to-frame collector: gathers FRAME_LEN bits and reports their parity and
// 1-bit count through a valid/ready result port, with a count of consumed frames.
module frame_parity_collector #(
  parameter int FRAME_LEN  = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_bit,
  output logic                           in_ready,
  input  logic                           in_abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_parity,
  output logic [$clog2(FRAME_LEN+1)-1:0] out_ones,
  output logic [7:0]                     out_frame_cnt
);

  localparam int ONES_W = $clog2(FRAME_LEN + 1);
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                acc_q, acc_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                parity_q, parity_d;
  logic [ONES_W-1:0]   res_ones_q, res_ones_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic last_bit;

  // In HOLD a new bit may only enter when the pending result leaves in the same cycle.
  assign in_ready  = rst_n && ((state_q == COLLECT) || out_ready);
  assign out_valid = (state_q == HOLD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_bit  = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    // NOTE: every signal gets its default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    parity_d    = parity_q;
    res_ones_d  = res_ones_q;
    frame_cnt_d = frame_cnt_q;

    if (out_xfer) begin
      state_d     = COLLECT;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if ((state_q == COLLECT) && in_abort) begin
      acc_d  = 1'b0;
      ones_d = '0;
      cnt_d  = '0;
    end else if (in_xfer) begin
      if (last_bit) begin
        // Overrides the COLLECT return above, which keeps FRAME_LEN == 1 in HOLD.
        parity_d   = acc_q ^ in_bit ^ 1'(ODD_PARITY);
        res_ones_d = ones_q + ONES_W'(in_bit);
        acc_d      = 1'b0;
        ones_d     = '0;
        cnt_d      = '0;
        state_d    = HOLD;
      end else begin
        acc_d  = acc_q ^ in_bit;
        ones_d = ones_q + ONES_W'(in_bit);
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      acc_q       <= 1'b0;
      ones_q      <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      res_ones_q  <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      res_ones_q  <= res_ones_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_parity    = parity_q;
  assign out_ones      = res_ones_q;
  assign out_frame_cnt = frame_cnt_q;

endmodule

// File: doc/frame_parity_collector.md
FRAME_PARITY_COLLECTOR -- requirements
Module: frame_parity_collector

Interface
REQ-001 Parameter FRAME_LEN, default 4: number of serial bits per frame; legal range 1..255.
REQ-002 Parameter ODD_PARITY, default 0: 0 = even parity (XOR of bits), 1 = odd parity (inverted XOR).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_bit carries a valid serial bit.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 in_ready  output  1  block accepts in_bit this cycle.
REQ-008 in_abort  input  1  discard the partially collected frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  downstream consumes result this cycle.
REQ-011 out_parity  output  1  frame parity per REQ-002.
REQ-012 out_ones  output  $clog2(FRAME_LEN+1)  count of 1-bits in the frame.
REQ-013 out_frame_cnt  output  8  completed-and-consumed frame count, wraps 255->0.

Function
REQ-014 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-015 Two states: COLLECT (accumulating bits) and HOLD (result pending).
REQ-016 in_ready = 1 in COLLECT; in HOLD, in_ready = out_ready (combinational).
REQ-017 Per input transfer: acc <= acc ^ in_bit, ones <= ones + in_bit, bit_cnt <= bit_cnt + 1.
REQ-018 On the input transfer with bit_cnt == FRAME_LEN-1: out_parity <= acc ^ in_bit ^ ODD_PARITY, out_ones <= ones + in_bit, out_valid <= 1, acc/ones/bit_cnt <= 0, state <= HOLD.
REQ-019 Result latency: out_valid rises on the clock edge that accepts the last bit of the frame; it is visible in the following cycle.
REQ-020 In HOLD, out_valid, out_parity, out_ones are held stable until an output transfer.
REQ-021 On output transfer in HOLD without input transfer: out_valid <= 0, state <= COLLECT, out_frame_cnt increments.
REQ-022 On simultaneous output and input transfer in HOLD: the input bit is the first bit of the next frame (REQ-017 applies); state <= COLLECT, out_frame_cnt increments.
REQ-023 FRAME_LEN == 1, simultaneous transfers in HOLD: new result is loaded, out_valid stays 1, state stays HOLD, out_frame_cnt increments.
REQ-024 in_abort in COLLECT: acc/ones/bit_cnt <= 0 and any same-cycle input bit is dropped; in HOLD, in_abort is ignored and the pending result is kept.
REQ-025 out_frame_cnt counts output transfers only; it wraps 255 -> 0 without a flag.
REQ-026 bit_cnt never exceeds FRAME_LEN-1; out_ones never exceeds FRAME_LEN.

Reset
REQ-027 rst_n low asynchronously forces state COLLECT, acc = 0, ones = 0, bit_cnt = 0, out_valid = 0, out_parity = 0, out_ones = 0, out_frame_cnt = 0.
REQ-028 While rst_n is low, in_ready = 0; after release, in_ready = 1 from the first clock edge.
REQ-029 Reset mid-frame or in HOLD discards partial and pending results; no output transfer occurs.

Verification (FRAME_LEN = 4, ODD_PARITY = 0 unless stated)
REQ-030 Bits 1,0,1,1 streamed back-to-back, out_ready = 1 -> out_valid for 1 cycle, out_parity = 1, out_ones = 3, out_frame_cnt = 1 afterwards.
REQ-031 Bits 1,1,0,0 with out_ready = 0 for 5 cycles -> out_valid held, out_parity = 0, out_ones = 2 stable, in_ready = 0; then out_ready = 1 clears it.
REQ-032 Frames 1,0,0,0 then 1,1,1,1 with no gap, out_ready = 1 in HOLD -> results (1,1) then (0,4), no bit lost, out_frame_cnt = 2.
REQ-033 Bits 1,1, in_abort, then 0,0,0,1 -> single result out_parity = 1, out_ones = 1.
REQ-034 ODD_PARITY = 1, bits 0,0,0,0 -> out_parity = 1, out_ones = 0.
REQ-035 rst_n pulsed low after 2 bits and again while in HOLD -> all outputs 0 immediately, next full frame produces a correct result, out_frame_cnt restarts at 0.
